// File: rtl/uart_rx_shift_fifo_if.sv
// Receive-path bundle for uart_rx_shift_fifo: serial input strobes from the
// bit timer (master) and the FIFO pop/status side returned by the block (slave).
interface uart_rx_shift_fifo_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              Rx;
   logic              shift;
   logic              load_buffer;
   logic              Rd_en;
   logic              clr_ovrflw;
   logic [DATA_W-1:0] rx_data_out;
   logic              parity_err;
   logic              d_valid;
   logic              overflow;
   logic [CNT_W-1:0]  count;

   modport master (
      output Rx, shift, load_buffer, Rd_en, clr_ovrflw,
      input  rx_data_out, parity_err, d_valid, overflow, count
   );

   modport slave (
      input  Rx, shift, load_buffer, Rd_en, clr_ovrflw,
      output rx_data_out, parity_err, d_valid, overflow, count
   );
endinterface

// File: rtl/uart_rx_shift_fifo.sv
// UART receive shift register feeding a DEPTH-entry frame FIFO with sticky overflow.
// Optional even-parity capture is enabled by defining UART_RX_PARITY_EN.
module uart_rx_shift_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                 CLOCK,
   input  logic                 reset,
   uart_rx_shift_fifo_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef UART_RX_PARITY_EN
   localparam int SR_W = DATA_W + 1;
`else
   localparam int SR_W = DATA_W;
`endif

   logic [SR_W-1:0]   sr_q, sr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              dvalid_q, dvalid_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;

   always_comb begin
      full  = (count_q == CNT_W'(DEPTH));
      empty = (count_q == '0);
      pop   = bus.Rd_en && !empty;
      // A pop in the same cycle frees the slot a full FIFO needs for the push.
      push  = bus.load_buffer && (!full || pop);

      sr_d = sr_q;
      if (bus.shift) begin
         sr_d = {bus.Rx, sr_q[SR_W-1:1]};
      end

      wr_ptr_d = wr_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_d = rd_ptr_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      data_d = data_q;
      if (bus.Rd_en) begin
         data_d = pop ? mem_q[rd_ptr_q] : '0;
      end

      dvalid_d = (count_d != '0);

      ovf_d = ovf_q;
      if (bus.clr_ovrflw) begin
         ovf_d = 1'b0;
      end else if (bus.load_buffer && full && !bus.Rd_en) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         sr_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         dvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
         dvalid_q <= dvalid_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is not reset; occupancy is tracked entirely by the pointers/count.
   always_ff @(posedge CLOCK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= sr_q[DATA_W-1:0];
      end
   end

`ifdef UART_RX_PARITY_EN
   logic mem_par_q [DEPTH];
   logic perr_q, perr_d;

   always_comb begin
      perr_d = perr_q;
      if (bus.Rd_en) begin
         perr_d = pop ? mem_par_q[rd_ptr_q] : 1'b0;
      end
   end

   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (push) begin
         mem_par_q[wr_ptr_q] <= ^sr_q;
      end
   end

   assign bus.parity_err = perr_q;
`else
   assign bus.parity_err = 1'b0;
`endif

   assign bus.rx_data_out = data_q;
   assign bus.d_valid     = dvalid_q;
   assign bus.overflow    = ovf_q;
   assign bus.count       = count_q;
endmodule
